// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the command sequencer.
// Holds the command frame width, the fn encodings, the command layout
// and the issue FSM state type.
package cmd_seq_pkg;

    // Serial command frame width: data[3:0] followed by fn[1:0]
    localparam int CMD_W = 6;

    // fn encodings seen by the user module
    localparam logic [1:0] FN_NOP  = 2'b00;
    localparam logic [1:0] FN_LOAD = 2'b01;
    localparam logic [1:0] FN_OP2  = 2'b10;
    localparam logic [1:0] FN_OP3  = 2'b11;

    // Frame layout as it arrives MSB first
    typedef struct packed {
        logic [3:0] data;
        logic [1:0] fn;
    } cmd_t;

    // Issue FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for buffered command frames.
// Ports: clk, rst_n (async active-low), push/din write side, pop/dout read
// side (dout shows the head entry combinationally), full/empty status.
// A push while full is accepted only when a pop happens on the same edge.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == {CNT_W{1'b0}});
    assign dout    = mem_q[rd_ptr_q];
    assign rd_en_s = pop & ~empty;
    // When full, the slot being written is the one being read this edge
    assign wr_en_s = push & (~full | rd_en_s);

    // Next pointer and occupancy; power-of-two depth lets pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_en_s ? (wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d = rd_en_s ? (rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1}) : rd_ptr_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Serial command feeder for the 4-bit user module.
// Deserialises 6-bit frames (data[3:0] then fn[1:0], MSB first) from
// ser_dat while ser_en is high, buffers them, and replays each as
// data_out/fn_out held HOLD_CYCLES clocks followed by GAP_CYCLES of fn=00.
// Ports: clk, rst_n (async active-low), ser_en/ser_dat serial input,
// hold (blocks starting a new issue), clr_ovf (clears overflow),
// fn_out/data_out (registered), busy, fifo_full, overflow (sticky drop flag).
module cmd_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_en,
    input  logic       ser_dat,
    input  logic       hold,
    input  logic       clr_ovf,
    output logic [1:0] fn_out,
    output logic [3:0] data_out,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    import cmd_seq_pkg::*;

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [2:0]       LAST_BIT  = 3'd5;

    // Deserialiser: only five bits are stored, the sixth is taken straight from ser_dat
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [4:0]       shift_q, shift_d;
    logic             frame_push_s;
    logic [CMD_W-1:0] frame_s;

    logic             ovf_q, ovf_d;
    logic             drop_s;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CMD_W-1:0] fifo_dout_s;
    cmd_t             head_s;
    logic             pop_s;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fn_q, fn_d;
    logic [3:0]       data_q, data_d;

    assign frame_s = {shift_q, ser_dat};
    assign head_s  = fifo_dout_s;

    // Shift in serial bits; an early ser_en drop discards the partial frame
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        frame_push_s = 1'b0;
        if (ser_en) begin
            shift_d = {shift_q[3:0], ser_dat};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d    = 3'd0;
                frame_push_s = 1'b1;
            end else begin
                bit_cnt_d    = bit_cnt_q + 3'd1;
                frame_push_s = 1'b0;
            end
        end else begin
            bit_cnt_d    = 3'd0;
            frame_push_s = 1'b0;
        end
    end

    // Sticky overflow; a drop on the same edge as clr_ovf keeps the flag set
    always_comb begin
        drop_s = frame_push_s & fifo_full_s & ~pop_s;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (frame_push_s),
        .din   (frame_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Issue FSM next state and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        data_d  = data_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                fn_d = FN_NOP;
                if (!fifo_empty_s && !hold) begin
                    pop_s   = 1'b1;
                    data_d  = head_s.data;
                    fn_d    = head_s.fn;
                    cnt_d   = HOLD_LOAD;
                    state_d = ISSUE;
                end else begin
                    pop_s   = 1'b0;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    fn_d = FN_NOP;
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            GAP: begin
                fn_d = FN_NOP;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                fn_d    = FN_NOP;
                state_d = IDLE;
            end
        endcase
    end

    // Deserialiser and overflow state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 5'd0;
            ovf_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ovf_q     <= ovf_d;
        end
    end

    // Issue FSM with its registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            fn_q    <= FN_NOP;
            data_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fn_q    <= fn_d;
            data_q  <= data_d;
        end
    end

    assign fn_out    = fn_q;
    assign data_out  = data_q;
    assign overflow  = ovf_q;
    assign fifo_full = fifo_full_s;
    assign busy      = (state_q != IDLE) | ~fifo_empty_s;

endmodule
